// File: rtl/conv_pkg.sv
// conv_pkg: frame constants, generator taps and framing state enum for conv_encoder
package conv_pkg;
  localparam int INFO_BITS  = 62;
  localparam int TAIL_BITS  = 2;
  localparam int FRAME_BITS = 128;
  localparam int GAP_CYCLES = 34;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  typedef enum logic [1:0] {DATA, TAIL, GAP} state_e;
endpackage

// File: rtl/conv_core.sv
// conv_core: K=3 shift register and generator XORs (clk, rst_n, b, step in; g0, g1 out)
module conv_core
  import conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  input  logic step,
  output logic g0,
  output logic g1
);
  logic s1_q, s2_q;
  // Taps are ordered {b, s1, s2}, MSB = newest bit.
  assign g0 = ^({b, s1_q, s2_q} & G0);
  assign g1 = ^({b, s1_q, s2_q} & G1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (step) begin
      s1_q <= b;
      s2_q <= s1_q;
    end
  end
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 K=3 encoder; in: clk, rst_n, in_bit, in_valid; out: in_ready, out_bit, out_valid, frame_done
module conv_encoder
  import conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  output logic frame_done
);
  state_e     state_q, state_d;
  logic [5:0] info_q, info_d, gap_q, gap_d;
  logic [1:0] tail_q, tail_d;
  logic [6:0] coded_q, coded_d;
  logic       pend_q, b_q, b_d;
  logic       out_bit_q, out_bit_d, out_valid_q, frame_done_q, in_ready_q, in_ready_d;
  logic       accept, tail_g0, emit_g0, emit, core_b, g0, g1;
  assign accept  = in_valid & in_ready_q;
  assign tail_g0 = (state_q == TAIL) & ~pend_q;
  assign emit_g0 = accept | tail_g0;
  assign emit    = emit_g0 | pend_q;
  // b_q is only consumed the cycle right after a G0, so tail bits latch a 0 here.
  assign b_d     = accept & in_bit;
  assign core_b  = pend_q ? b_q : b_d;
  conv_core u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .b    (core_b),
    .step (pend_q),
    .g0   (g0),
    .g1   (g1)
  );
  always_comb begin
    state_d   = state_q;
    info_d    = accept ? info_q + 6'd1 : info_q;
    tail_d    = (state_q == TAIL && pend_q) ? tail_q + 2'd1 : tail_q;
    gap_d     = (state_q == GAP) ? gap_q + 6'd1 : gap_q;
    coded_d   = emit ? coded_q + 7'd1 : coded_q;
    out_bit_d = emit_g0 ? g0 : (pend_q & g1);
    case (state_q)
      DATA: if (pend_q && info_q == 6'(INFO_BITS)) state_d = TAIL;
      TAIL: if (pend_q && tail_q == 2'(TAIL_BITS - 1)) begin
        state_d = GAP;
        tail_d  = 2'd0;
        info_d  = 6'd0;
        coded_d = 7'd0;
      end
      GAP: if (gap_q == 6'(GAP_CYCLES - 1)) begin
        state_d = DATA;
        gap_d   = 6'd0;
      end
      default: state_d = DATA;
    endcase
    in_ready_d = (state_d == DATA) && !emit_g0 && (info_d < 6'(INFO_BITS));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= DATA;
      info_q       <= 6'd0;
      tail_q       <= 2'd0;
      gap_q        <= 6'd0;
      coded_q      <= 7'd0;
      pend_q       <= 1'b0;
      b_q          <= 1'b0;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      info_q       <= info_d;
      tail_q       <= tail_d;
      gap_q        <= gap_d;
      coded_q      <= coded_d;
      pend_q       <= emit_g0;
      b_q          <= b_d;
      out_bit_q    <= out_bit_d;
      out_valid_q  <= emit;
      frame_done_q <= emit && coded_q == 7'(FRAME_BITS - 1);
      in_ready_q   <= in_ready_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
endmodule
